// File: rtl/maxnet_controller_if.sv
// Control bundle between the MAXNET controller and its datapath.
// master = controller side, slave = datapath/consumer side.
interface maxnet_controller_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             ack;
  logic             done;
  logic             ldX;
  logic             ldTmp;
  logic             selTmp;
  logic             busy;
  logic             valid;
  logic             error;
  logic [CNT_W-1:0] iter_count;

  modport master (
    input  start,
    input  ack,
    input  done,
    output ldX,
    output ldTmp,
    output selTmp,
    output busy,
    output valid,
    output error,
    output iter_count
  );

  modport slave (
    output start,
    output ack,
    output done,
    input  ldX,
    input  ldTmp,
    input  selTmp,
    input  busy,
    input  valid,
    input  error,
    input  iter_count
  );
endinterface

// File: rtl/maxnet_controller.sv
// MAXNET iteration controller: load, wait for PU settle, update,
// check convergence; Moore outputs decoded from the state register.
module maxnet_controller #(
  parameter int PU_LATENCY = 2,
  parameter int MAX_ITER   = 31,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  maxnet_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_WAIT,
    S_UPDATE,
    S_RESULT,
    S_FAIL
  } state_t;

  localparam logic [3:0] WLAST =
    4'(PU_LATENCY - 1);
  localparam logic [CNT_W-1:0] IMAX =
    CNT_W'(MAX_ITER);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_wcnt;
  logic [CNT_W-1:0] r_iter;

  logic w_ldX;
  logic w_ldTmp;
  logic w_selTmp;
  logic w_busy;
  logic w_valid;
  logic w_error;

  // State register; reset forces IDLE at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Settle counter: cleared leaving CHECK, counts in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_wcnt <= '0;
    else if (r_state == S_CHECK) r_wcnt <= '0;
    else if (r_state == S_WAIT)  r_wcnt <= r_wcnt + 4'd1;
  end

  // Iteration counter: cleared in LOAD, bumped per UPDATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_iter <= '0;
    else if (r_state == S_LOAD)   r_iter <= '0;
    else if (r_state == S_UPDATE) r_iter <= r_iter + 1'b1;
  end

  // Next-state: done is only trusted in CHECK, after tmp settles.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_LOAD;
      S_LOAD:   w_next = S_CHECK;
      S_CHECK: begin
        if (bus.done)            w_next = S_RESULT;
        else if (r_iter == IMAX) w_next = S_FAIL;
        else                     w_next = S_WAIT;
      end
      S_WAIT:   if (r_wcnt == WLAST) w_next = S_UPDATE;
      S_UPDATE: w_next = S_CHECK;
      S_RESULT: if (bus.ack) w_next = S_IDLE;
      S_FAIL:   if (bus.ack) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    w_ldX    = 1'b0;
    w_ldTmp  = 1'b0;
    w_selTmp = 1'b0;
    w_busy   = 1'b0;
    w_valid  = 1'b0;
    w_error  = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_ldX   = 1'b1;
        w_ldTmp = 1'b1;
        w_busy  = 1'b1;
      end
      S_CHECK: w_busy = 1'b1;
      S_WAIT: begin
        w_selTmp = 1'b1;
        w_busy   = 1'b1;
      end
      S_UPDATE: begin
        w_ldTmp  = 1'b1;
        w_selTmp = 1'b1;
        w_busy   = 1'b1;
      end
      S_RESULT: w_valid = 1'b1;
      S_FAIL:   w_error = 1'b1;
      default: ;
    endcase
  end

  assign bus.ldX        = w_ldX;
  assign bus.ldTmp      = w_ldTmp;
  assign bus.selTmp     = w_selTmp;
  assign bus.busy       = w_busy;
  assign bus.valid      = w_valid;
  assign bus.error      = w_error;
  assign bus.iter_count = r_iter;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller (PU_LATENCY=2,
// MAX_ITER=31): convergence, timeout, handshake, hold, reset.
module tb_maxnet_controller;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  maxnet_controller_if #(.CNT_W(5)) bus ();

  maxnet_controller #(
    .PU_LATENCY(2),
    .MAX_ITER  (31),
    .CNT_W     (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin : main
    int n;
    int ld_upd;
    int ldx_cnt;
    int vat;
    int eat;
    int ok_pre;
    logic lt_h [0:39];
    logic st_h [0:39];

    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.done  = 1'b0;

    // Reset state
    #12;
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_iter",  int'(bus.iter_count), 0);
    chk("rst_ldx",   int'(bus.ldX),   0);
    rst = 1'b1;
    tick();
    tick();
    chk("idle_stay", int'(bus.busy), 0);

    // Immediate convergence
    bus.done  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("imm_ldx",    int'(bus.ldX),    1);
    chk("imm_ldtmp",  int'(bus.ldTmp),  1);
    chk("imm_seltmp", int'(bus.selTmp), 0);
    chk("imm_busy",   int'(bus.busy),   1);
    tick();
    chk("imm_chk_busy",  int'(bus.busy),  1);
    chk("imm_chk_ldtmp", int'(bus.ldTmp), 0);
    chk("imm_chk_valid", int'(bus.valid), 0);
    tick();
    chk("imm_valid", int'(bus.valid), 1);
    chk("imm_iter",  int'(bus.iter_count), 0);
    chk("imm_busy0", int'(bus.busy), 0);

    // Hold in RESULT with ack low
    bus.done = 1'b0;
    ok_pre   = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid !== 1'b1 ||
          bus.iter_count !== 5'd0 ||
          bus.ldX !== 1'b0 ||
          bus.ldTmp !== 1'b0)
        ok_pre = 0;
    end
    chk("hold_stable", ok_pre, 1);

    // start+ack together in RESULT -> IDLE, start dropped
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    chk("sa_idle_valid", int'(bus.valid), 0);
    chk("sa_idle_busy",  int'(bus.busy),  0);
    tick();
    chk("sa_noload_ldx",  int'(bus.ldX),  0);
    chk("sa_noload_busy", int'(bus.busy), 0);

    // Normal run: converge after 3 updates; start pulse in WAIT
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vat     = -1;
    ldx_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      lt_h[k] = bus.ldTmp;
      st_h[k] = bus.selTmp;
      if (bus.ldX === 1'b1) ldx_cnt++;
      if (bus.valid === 1'b1 && vat < 0) vat = k;
      if (vat >= 0) break;
      bus.start = (k == 2);
      bus.done  = (bus.iter_count == 5'd3);
      tick();
    end
    bus.start = 1'b0;
    bus.done  = 1'b0;
    chk("run_latency", vat, 14);
    chk("run_iter",    int'(bus.iter_count), 3);
    chk("run_ldx_cnt", ldx_cnt, 1);
    ld_upd = 0;
    ok_pre = 1;
    for (int k = 2; k < 40; k++) begin
      if (k > vat) break;
      if (lt_h[k] === 1'b1 && st_h[k] === 1'b1) begin
        ld_upd++;
        if (!(st_h[k-1] === 1'b1 && lt_h[k-1] === 1'b0 &&
              st_h[k-2] === 1'b1 && lt_h[k-2] === 1'b0))
          ok_pre = 0;
      end
    end
    chk("run_updates",   ld_upd, 3);
    chk("run_wait_pre",  ok_pre, 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("run_ack_idle", int'(bus.valid), 0);

    // Timeout
    bus.done  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    eat = -1;
    n   = 0;
    while (n < 200 && eat < 0) begin
      if (bus.error === 1'b1) eat = n;
      else begin
        tick();
        n++;
      end
    end
    chk("to_latency", eat, 126);
    chk("to_error",   int'(bus.error), 1);
    chk("to_valid",   int'(bus.valid), 0);
    chk("to_iter",    int'(bus.iter_count), 31);
    chk("to_busy",    int'(bus.busy), 0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("to_ack_err",  int'(bus.error), 0);
    chk("to_ack_busy", int'(bus.busy),  0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("to_relaunch_ldx", int'(bus.ldX), 1);
    tick();
    chk("to_relaunch_iter", int'(bus.iter_count), 0);

    // Async reset in WAIT with iter_count=2 (obs 10)
    for (int k = 2; k <= 10; k++) tick();
    chk("mid_iter",   int'(bus.iter_count), 2);
    chk("mid_seltmp", int'(bus.selTmp), 1);
    chk("mid_ldtmp",  int'(bus.ldTmp),  0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_iter",   int'(bus.iter_count), 0);
    chk("arst_busy",   int'(bus.busy),   0);
    chk("arst_seltmp", int'(bus.selTmp), 0);
    chk("arst_ldx",    int'(bus.ldX),    0);
    chk("arst_valid",  int'(bus.valid),  0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_busy",  int'(bus.busy),  0);
    chk("post_rst_ldx",   int'(bus.ldX),   0);
    chk("post_rst_iter",  int'(bus.iter_count), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
